// File: rtl/alu_issue.sv
// alu_issue: operand-issue and writeback stage around a 32-bit combinational ALU.
// Holds an 8 x 32-bit register file (r0 hardwired to zero), accepts one
// instruction per valid/ready handshake, registers operands into the ALU,
// captures the ALU result/flags, and writes the result back.
// One instruction is in flight at a time: IDLE -> EXEC -> WB -> IDLE.
module alu_issue #(
  parameter int NREG = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_func,
  input  logic [2:0]  i_rs,
  input  logic [2:0]  i_rt,
  input  logic [2:0]  i_rd,
  input  logic        i_imm_en,
  input  logic [31:0] i_imm,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_func,
  input  logic [31:0] i_alu_y,
  input  logic        i_alu_c,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic        o_carry,
  output logic        o_zero,
  input  logic [2:0]  i_dbg_addr,
  output logic [31:0] o_dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Instruction fields captured at accept time.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic [2:0]  rd;
  } issue_req_t;

  state_t      state, state_nxt;
  logic [31:0] regs [NREG];
  issue_req_t  req_d, req_q;
  logic        accept;
  logic        wb_en;
  logic [31:0] rs_data, rt_data;

  // r0 is never written, but the explicit zero mux keeps reads correct
  // regardless of what the storage element holds.
  assign rs_data    = (i_rs == 3'd0)       ? 32'd0 : regs[i_rs];
  assign rt_data    = (i_rt == 3'd0)       ? 32'd0 : regs[i_rt];
  assign o_dbg_data = (i_dbg_addr == 3'd0) ? 32'd0 : regs[i_dbg_addr];

  assign accept = i_valid & o_ready;
  assign wb_en  = (state == WB) && (req_q.rd != 3'd0);

  // Operand selection for the instruction being offered this cycle.
  always_comb begin
    req_d      = '0;
    req_d.a    = rs_data;
    req_d.b    = i_imm_en ? i_imm : rt_data;
    req_d.func = i_func;
    req_d.rd   = i_rd;
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = WB;
      end
      WB: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand/function registers feeding the ALU; held between accepts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       req_q <= '0;
    else if (accept) req_q <= req_d;
  end

  assign o_alu_a    = req_q.a;
  assign o_alu_b    = req_q.b;
  assign o_alu_func = req_q.func;

  // Result and flags are captured only at the end of EXEC. Carry is only
  // meaningful for add/subtract (func[1:0] == 2'b10) and reads 0 otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result <= '0;
      o_carry  <= 1'b0;
      o_zero   <= 1'b0;
    end else if (state == EXEC) begin
      o_result <= i_alu_y;
      o_carry  <= (req_q.func[1:0] == 2'b10) ? i_alu_c : 1'b0;
      o_zero   <= (i_alu_y == 32'd0);
    end
  end

  // Register file writeback at the end of WB; the write lands before the
  // next accept can sample it, so no forwarding path is required.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[req_q.rd] <= o_result;
    end
  end

endmodule
